// File: rtl/grid_ram_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// AocPkg
// Shared types and constants for the grid RAM sequencer and solver.
// Revision: 1.0 - initial release
// ============================================================================
package AocPkg;

   // Default grid RAM depth. The address type is sized from it.
   localparam int unsigned RAM_DEPTH_DFLT = 32768;
   localparam int unsigned RAM_ADDR_W     = $clog2(RAM_DEPTH_DFLT);

   typedef logic [RAM_ADDR_W-1:0] RamAddr_t;

   // End-of-text marker appended after the host grid. It tells the solver
   // where the puzzle input stops.
   localparam logic [7:0] ASCII_EOT = 8'h04;

   // Sequencer phases of one puzzle run
   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_LOAD  = 3'd1,
      SEQ_EOT   = 3'd2,
      SEQ_RUN   = 3'd3,
      SEQ_DONE  = 3'd4,
      SEQ_ERROR = 3'd5
   } SeqFsm_e;

endpackage : AocPkg
`default_nettype wire

// File: rtl/grid_ram_sequencer.sv
`default_nettype none
// ============================================================================
// grid_ram_sequencer
// Owns the grid RAM ports and sequences a puzzle run: host load, EOT append,
// solver run with timeout, result capture and debug read-back.
// Revision: 1.0 - initial release
// ============================================================================
module grid_ram_sequencer
   import AocPkg::*;
#(
   parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DFLT,
   parameter int unsigned MAX_CYCLES = 2**24
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic                  LoadValid,
   output logic                  LoadReady,
   input  logic [7:0]            LoadData,
   input  logic                  LoadLast,
   output logic [RAM_ADDR_W-1:0] RamWriteAddr,
   output logic                  RamWriteEnable,
   output logic [7:0]            RamWriteData,
   output logic [RAM_ADDR_W-1:0] RamReadAddr,
   output logic                  RamReadEnable,
   input  logic [7:0]            RamReadData,
   output logic                  SolverHold,
   input  logic [RAM_ADDR_W-1:0] SolverReadAddr,
   input  logic                  SolverReadEnable,
   output logic [7:0]            SolverReadData,
   input  logic [RAM_ADDR_W-1:0] SolverWriteAddr,
   input  logic                  SolverWriteEnable,
   input  logic [7:0]            SolverWriteData,
   input  logic                  SolverDone,
   input  logic                  SolverError,
   input  logic [15:0]           SolverAnswer,
   input  logic                  DbgReadReq,
   input  logic [RAM_ADDR_W-1:0] DbgReadAddr,
   output logic [7:0]            DbgReadData,
   output logic                  DbgReadDataValid,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Error,
   output logic [15:0]           Answer,
   output logic [31:0]           CycleCount
);

   // Last data slot that still leaves room for the EOT byte behind it
   localparam RamAddr_t    PTR_LAST_DATA = RamAddr_t'(RAM_DEPTH - 2);
   // Slot reserved for EOT only; no host byte may land here
   localparam RamAddr_t    PTR_EOT_ONLY  = RamAddr_t'(RAM_DEPTH - 1);
   localparam logic [31:0] CYCLE_LIMIT   = 32'(MAX_CYCLES - 1);

   SeqFsm_e     state_q, state_d;
   RamAddr_t    ptr_q, ptr_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic [15:0] answer_q, answer_d;
   logic        hold_q, hold_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        dbg_valid_q, dbg_valid_d;

   logic        quiet;
   logic        load_ready;
   logic        load_beat;
   logic        dbg_take;

   // Host and debug handshakes are only honoured in their owning phases
   always_comb begin
      quiet      = (state_q == SEQ_IDLE) || (state_q == SEQ_DONE) ||
                   (state_q == SEQ_ERROR);
      load_ready = (state_q == SEQ_LOAD) && (ptr_q != PTR_EOT_ONLY);
      load_beat  = LoadValid && load_ready;
      dbg_take   = quiet && DbgReadReq;
   end

   // Next-state, pointer, run counter and result capture
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cycle_count_d = cycle_count_q;
      answer_d      = answer_q;
      case (state_q)
         SEQ_IDLE, SEQ_DONE, SEQ_ERROR: begin
            if (Start) begin
               state_d       = SEQ_LOAD;
               ptr_d         = '0;
               cycle_count_d = '0;
               answer_d      = '0;
            end
         end
         SEQ_LOAD: begin
            if (load_beat) begin
               ptr_d = ptr_q + 1'b1;
               if (LoadLast) begin
                  state_d = SEQ_EOT;
               end else if (ptr_q == PTR_LAST_DATA) begin
                  // Byte is still written, but EOT would have nowhere to go
                  state_d = SEQ_ERROR;
               end
            end
         end
         SEQ_EOT: begin
            state_d = SEQ_RUN;
         end
         SEQ_RUN: begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (SolverError) begin
               state_d = SEQ_ERROR;
            end else if (SolverDone) begin
               state_d  = SEQ_DONE;
               answer_d = SolverAnswer;
            end else if (cycle_count_q == CYCLE_LIMIT) begin
               state_d = SEQ_ERROR;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they track it
   always_comb begin
      hold_d      = (state_d != SEQ_RUN);
      busy_d      = (state_d == SEQ_LOAD) || (state_d == SEQ_EOT) ||
                    (state_d == SEQ_RUN);
      done_d      = (state_d == SEQ_DONE);
      error_d     = (state_d == SEQ_ERROR);
      dbg_valid_d = dbg_take;
   end

   // RAM port ownership: loader in LOAD/EOT, solver in RUN, debug when quiet
   always_comb begin
      RamWriteAddr   = ptr_q;
      RamWriteEnable = 1'b0;
      RamWriteData   = LoadData;
      RamReadAddr    = DbgReadAddr;
      RamReadEnable  = 1'b0;
      case (state_q)
         SEQ_LOAD: begin
            RamWriteEnable = load_beat;
         end
         SEQ_EOT: begin
            RamWriteEnable = 1'b1;
            RamWriteData   = ASCII_EOT;
         end
         SEQ_RUN: begin
            RamWriteAddr   = SolverWriteAddr;
            RamWriteEnable = SolverWriteEnable;
            RamWriteData   = SolverWriteData;
            RamReadAddr    = SolverReadAddr;
            RamReadEnable  = SolverReadEnable;
         end
         default: begin
            RamReadEnable = dbg_take;
         end
      endcase
   end

   // State and output registers; RAM contents are not affected by reset
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= SEQ_IDLE;
         ptr_q         <= '0;
         cycle_count_q <= '0;
         answer_q      <= '0;
         hold_q        <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         dbg_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cycle_count_q <= cycle_count_d;
         answer_q      <= answer_d;
         hold_q        <= hold_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         dbg_valid_q   <= dbg_valid_d;
      end
   end

   // The solver is held outside RUN, so it never acts on debug read data
   always_comb begin
      LoadReady        = load_ready;
      SolverHold       = hold_q;
      SolverReadData   = RamReadData;
      DbgReadData      = RamReadData;
      DbgReadDataValid = dbg_valid_q;
      Busy             = busy_q;
      Done             = done_q;
      Error            = error_q;
      Answer           = answer_q;
      CycleCount       = cycle_count_q;
   end

endmodule : grid_ram_sequencer
`default_nettype wire

// File: tb/tb_grid_ram_sequencer.sv
`default_nettype none
// ============================================================================
// tb_grid_ram_sequencer
// Directed bench: two sequencers share stimulus; A has a long run limit,
// B a 64-cycle limit so its timeout shows up while A keeps running.
// Revision: 1.0 - initial release
// ============================================================================
module tb_grid_ram_sequencer;
   import AocPkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start, load_valid, load_last;
   logic [7:0]            load_data;
   logic [RAM_ADDR_W-1:0] s_raddr, s_waddr, dbg_addr;
   logic                  s_re, s_we, s_done, s_err, dbg_req;
   logic [7:0]            s_wdata;
   logic [15:0]           s_ans;

   logic                  a_load_ready, a_we, a_re, a_hold, a_dbg_valid;
   logic                  a_busy, a_done, a_error;
   logic [RAM_ADDR_W-1:0] a_waddr, a_raddr;
   logic [7:0]            a_wdata, a_rdata, a_srdata, a_dbg_data;
   logic [15:0]           a_answer;
   logic [31:0]           a_cc;

   logic                  b_load_ready, b_we, b_re, b_hold, b_dbg_valid;
   logic                  b_busy, b_done, b_error;
   logic [RAM_ADDR_W-1:0] b_waddr, b_raddr;
   logic [7:0]            b_wdata, b_rdata, b_srdata, b_dbg_data;
   logic [15:0]           b_answer;
   logic [31:0]           b_cc;

   logic [7:0] mem_a [16] = '{default: 8'hEE};
   string      grid = "@.@\n.@.\n@.@\n";
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   grid_ram_sequencer #(.RAM_DEPTH(16), .MAX_CYCLES(1024)) u_dut_a (
      .Clk(clk), .Rst(rst), .Start(start),
      .LoadValid(load_valid), .LoadReady(a_load_ready), .LoadData(load_data), .LoadLast(load_last),
      .RamWriteAddr(a_waddr), .RamWriteEnable(a_we), .RamWriteData(a_wdata),
      .RamReadAddr(a_raddr), .RamReadEnable(a_re), .RamReadData(a_rdata),
      .SolverHold(a_hold), .SolverReadAddr(s_raddr), .SolverReadEnable(s_re),
      .SolverReadData(a_srdata), .SolverWriteAddr(s_waddr), .SolverWriteEnable(s_we),
      .SolverWriteData(s_wdata), .SolverDone(s_done), .SolverError(s_err), .SolverAnswer(s_ans),
      .DbgReadReq(dbg_req), .DbgReadAddr(dbg_addr), .DbgReadData(a_dbg_data),
      .DbgReadDataValid(a_dbg_valid), .Busy(a_busy), .Done(a_done), .Error(a_error),
      .Answer(a_answer), .CycleCount(a_cc)
   );

   grid_ram_sequencer #(.RAM_DEPTH(16), .MAX_CYCLES(64)) u_dut_b (
      .Clk(clk), .Rst(rst), .Start(start),
      .LoadValid(load_valid), .LoadReady(b_load_ready), .LoadData(load_data), .LoadLast(load_last),
      .RamWriteAddr(b_waddr), .RamWriteEnable(b_we), .RamWriteData(b_wdata),
      .RamReadAddr(b_raddr), .RamReadEnable(b_re), .RamReadData(b_rdata),
      .SolverHold(b_hold), .SolverReadAddr(s_raddr), .SolverReadEnable(s_re),
      .SolverReadData(b_srdata), .SolverWriteAddr(s_waddr), .SolverWriteEnable(s_we),
      .SolverWriteData(s_wdata), .SolverDone(s_done), .SolverError(s_err), .SolverAnswer(s_ans),
      .DbgReadReq(dbg_req), .DbgReadAddr(dbg_addr), .DbgReadData(b_dbg_data),
      .DbgReadDataValid(b_dbg_valid), .Busy(b_busy), .Done(b_done), .Error(b_error),
      .Answer(b_answer), .CycleCount(b_cc)
   );

   assign b_rdata = 8'h00;

   // Simple-dual-port RAM for DUT A, registered read
   always @(posedge clk) begin
      if (a_we) mem_a[a_waddr[3:0]] <= a_wdata;
      if (a_re) a_rdata <= mem_a[a_raddr[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
      s_raddr = '0; s_waddr = '0; s_re = 1'b0; s_we = 1'b0; s_wdata = 8'h00;
      s_done = 1'b0; s_err = 1'b0; s_ans = 16'h0; dbg_req = 1'b0; dbg_addr = '0;
      repeat (3) tick();

      // Reset values
      chk("rst_hold", a_hold, 1);
      chk("rst_load_ready", a_load_ready, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done_error", {a_done, a_error}, 0);
      chk("rst_answer", a_answer, 0);
      chk("rst_cycle_count", a_cc, 0);
      chk("rst_ram_strobes", {a_we, a_re, a_dbg_valid}, 0);
      rst = 1'b0;
      tick();

      // 3x3 grid load, EOT append, hold release
      start = 1'b1; tick(); start = 1'b0;
      chk("load_ready", a_load_ready, 1);
      chk("load_busy", a_busy, 1);
      for (int i = 0; i < 12; i++) beat(grid[i], i == 11);
      chk("eot_we", a_we, 1);
      chk("eot_addr", a_waddr, 12);
      chk("eot_data", a_wdata, 8'h04);
      chk("eot_hold", a_hold, 1);
      tick();
      chk("run_hold_a", a_hold, 0);
      chk("run_hold_b", b_hold, 0);
      for (int i = 0; i < 12; i++) chk("grid_byte", mem_a[i], grid[i]);
      chk("grid_eot", mem_a[12], 8'h04);

      // Run: debug ignored in RUN, B times out at 64, A done at cycle 500
      for (int k = 1; k <= 499; k++) begin
         if (k == 100) begin
            dbg_req = 1'b1; dbg_addr = 15'd12;
            #1;
            chk("run_dbg_no_read", a_re, 0);
         end
         tick();
         if (k == 100) begin
            chk("run_dbg_no_valid", a_dbg_valid, 0);
            dbg_req = 1'b0;
         end
         if (k == 63) chk("b_no_timeout_yet", b_error, 0);
         if (k == 64) begin
            chk("b_timeout_error", b_error, 1);
            chk("b_timeout_count", b_cc, 64);
            chk("b_timeout_hold", b_hold, 1);
         end
      end
      s_done = 1'b1; s_ans = 16'd13;
      tick();
      s_done = 1'b0;
      chk("a_done", a_done, 1);
      chk("a_answer", a_answer, 13);
      chk("a_cycle_count", a_cc, 500);
      chk("a_done_hold", a_hold, 1);
      chk("a_done_busy_err", {a_busy, a_error}, 0);

      // Debug read-back in DONE
      dbg_req = 1'b1; dbg_addr = 15'd12;
      #1;
      chk("dbg_read_en", a_re, 1);
      chk("dbg_read_addr", a_raddr, 12);
      tick();
      dbg_req = 1'b0;
      chk("dbg_valid", a_dbg_valid, 1);
      chk("dbg_data", a_dbg_data, 8'h04);
      tick();
      chk("dbg_valid_pulse", a_dbg_valid, 0);

      // Reset mid-load, then full reload from address 0
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) beat(8'h58, 1'b0);
      rst = 1'b1;
      #1;
      chk("midload_rst_busy", a_busy, 0);
      chk("midload_rst_ready", a_load_ready, 0);
      chk("midload_rst_hold", a_hold, 1);
      tick();
      rst = 1'b0;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      load_valid = 1'b1; load_data = grid[0]; load_last = 1'b0;
      #1;
      chk("reload_addr0", a_waddr, 0);
      chk("reload_we", a_we, 1);
      tick();
      load_valid = 1'b0;
      for (int i = 1; i < 12; i++) beat(grid[i], i == 11);
      chk("reload_eot_addr", a_waddr, 12);
      tick();
      chk("reload_run_hold", a_hold, 0);
      repeat (9) tick();
      s_done = 1'b1; s_ans = 16'd9;
      tick();
      s_done = 1'b0;
      chk("reload_done", a_done, 1);
      chk("reload_answer", a_answer, 9);
      chk("reload_cycle_count", a_cc, 10);

      // Overflow: 15 bytes without LoadLast on a 16-deep RAM
      start = 1'b1; tick(); start = 1'b0;
      chk("ovf_start_clears_answer", a_answer, 0);
      for (int i = 0; i < 15; i++) begin
         beat(8'h30 + 8'(i), 1'b0);
         if (i == 13) chk("ovf_not_yet", a_error, 0);
      end
      chk("ovf_error", a_error, 1);
      chk("ovf_ready_low", a_load_ready, 0);
      chk("ovf_busy", a_busy, 0);
      chk("ovf_last_byte", mem_a[14], 8'h3E);
      load_valid = 1'b1; load_data = 8'h55;
      #1;
      chk("ovf_no_write", a_we, 0);
      tick(); tick();
      load_valid = 1'b0;
      chk("ovf_slot15_untouched", mem_a[15], 8'hEE);

      // LoadLast on addr 14: EOT lands in the final slot
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 15; i++) beat(8'h40 + 8'(i), i == 14);
      chk("full_eot_addr", a_waddr, 15);
      chk("full_eot_we", a_we, 1);
      chk("full_eot_data", a_wdata, 8'h04);
      tick();
      chk("full_run_hold", a_hold, 0);
      chk("full_slot15", mem_a[15], 8'h04);

      // Error wins over Done in the same cycle
      s_err = 1'b1; s_done = 1'b1; s_ans = 16'd77;
      tick();
      s_err = 1'b0; s_done = 1'b0;
      chk("prio_error", a_error, 1);
      chk("prio_no_done", a_done, 0);
      chk("prio_answer_kept", a_answer, 0);
      chk("prio_hold", a_hold, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_grid_ram_sequencer
`default_nettype wire
